// File: rtl/seg7_scan_reader.sv
// seg7_scan_reader: decodes a scanned 4-digit 7-segment bus back to a stable 16-bit reading
module seg7_scan_reader #(
    parameter int STABLE_SCANS   = 3,
    parameter bit SEG_ACTIVE_LOW = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  dig_sel,
    input  logic [6:0]  seg,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_value,
    output logic        frame_err,
    output logic        overrun
);
    typedef enum logic {COLLECT, EVAL} state_t;
    localparam logic [3:0] S = 4'(STABLE_SCANS);
    state_t state, state_nx;
    logic [15:0] slot_nib, prev, last_rep;
    logic [3:0] slot_ok, seen, cnt, cnt_nx, dnib;
    logic [6:0] s;
    logic dok, accept, onehot, hs, all_ok, reportable, rep_seen;
    assign s = SEG_ACTIVE_LOW ? ~seg : seg;
    assign in_ready = (state == COLLECT);
    assign accept = in_valid && in_ready;
    assign onehot = (dig_sel != 4'd0) && ((dig_sel & (dig_sel - 4'd1)) == 4'd0);
    assign hs = out_valid && out_ready;
    assign all_ok = &slot_ok;
    // Segment pattern back to hex nibble; anything off-table is flagged invalid
    always_comb begin
        dok = 1'b1;
        dnib = 4'h0;
        case (s)
            7'h3F: dnib = 4'h0;
            7'h06: dnib = 4'h1;
            7'h5B: dnib = 4'h2;
            7'h4F: dnib = 4'h3;
            7'h66: dnib = 4'h4;
            7'h6D: dnib = 4'h5;
            7'h7D: dnib = 4'h6;
            7'h07: dnib = 4'h7;
            7'h7F: dnib = 4'h8;
            7'h6F: dnib = 4'h9;
            7'h77: dnib = 4'hA;
            7'h7C: dnib = 4'hB;
            7'h39: dnib = 4'hC;
            7'h5E: dnib = 4'hD;
            7'h79: dnib = 4'hE;
            7'h71: dnib = 4'hF;
            default: dok = 1'b0;
        endcase
    end
    // Frame evaluation: a handshake in the same cycle is treated as already completed
    always_comb begin
        cnt_nx = !all_ok ? 4'd0 : (slot_nib != prev) ? 4'd1 : (cnt >= S) ? S : cnt + 4'd1;
        reportable = all_ok && (cnt_nx == S) &&
                     (!(rep_seen || hs) || (slot_nib != (hs ? out_value : last_rep)));
    end
    // Next state: leave COLLECT when the accepting write fills the last seen bit
    always_comb begin
        state_nx = state;
        if (state == EVAL)
            state_nx = COLLECT;
        else if (accept && onehot && ((seen | dig_sel) == 4'hF))
            state_nx = EVAL;
    end
    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= COLLECT;
        else       state <= state_nx;
    end
    // Slot capture, stability tracking and output handshake
    always_ff @(posedge clk) begin
        if (reset) begin
            slot_nib  <= '0;
            slot_ok   <= '0;
            seen      <= '0;
            prev      <= '0;
            cnt       <= '0;
            last_rep  <= '0;
            rep_seen  <= 1'b0;
            out_valid <= 1'b0;
            out_value <= '0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            if (hs) begin
                out_valid <= 1'b0;
                last_rep  <= out_value;
                rep_seen  <= 1'b1;
            end
            if (accept) begin
                if (!onehot) frame_err <= 1'b1;
                else for (int i = 0; i < 4; i++) if (dig_sel[i]) begin
                    slot_nib[4*i +: 4] <= dnib;
                    slot_ok[i]         <= dok;
                    seen[i]            <= 1'b1;
                end
            end
            if (state == EVAL) begin
                seen      <= '0;
                cnt       <= cnt_nx;
                prev      <= slot_nib;
                frame_err <= !all_ok;
                if (reportable) begin
                    if (out_valid && !hs) overrun <= 1'b1;
                    else begin
                        out_value <= slot_nib;
                        out_valid <= 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_seg7_scan_reader.sv
// tb_seg7_scan_reader: directed-vector self-checking bench for seg7_scan_reader
module tb_seg7_scan_reader;
    logic clk = 1'b0;
    logic reset, in_valid, in_ready, out_valid, out_ready, frame_err, overrun;
    logic [3:0] dig_sel;
    logic [6:0] seg;
    logic [15:0] out_value;
    int n_checks = 0, n_fail = 0;
    int ov_rises = 0, fe_cnt = 0, b_ov = 0, b_fe = 0;
    logic ov_d = 1'b0;

    always #5 clk = ~clk;

    seg7_scan_reader #(.STABLE_SCANS(3), .SEG_ACTIVE_LOW(0)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .dig_sel(dig_sel), .seg(seg), .out_valid(out_valid), .out_ready(out_ready),
        .out_value(out_value), .frame_err(frame_err), .overrun(overrun)
    );

    // Count out_valid rising edges and frame_err pulse cycles
    always @(negedge clk) begin
        if (out_valid && !ov_d) ov_rises++;
        ov_d = out_valid;
        if (frame_err) fe_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset;
        reset = 1'b1;
        in_valid = 1'b0;
        tick(2);
        reset = 1'b0;
    endtask

    task automatic send(input logic [3:0] d, input logic [6:0] sg);
        int n = 0;
        dig_sel = d;
        seg = sg;
        in_valid = 1'b1;
        while (!in_ready && n < 8) begin
            tick(1);
            n++;
        end
        check("in_ready", in_ready, 1);
        tick(1);
        in_valid = 1'b0;
    endtask

    task automatic frame(input logic [6:0] s3, input logic [6:0] s2, input logic [6:0] s1, input logic [6:0] s0);
        send(4'b1000, s3);
        send(4'b0100, s2);
        send(4'b0010, s1);
        send(4'b0001, s0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        in_valid = 1'b0;
        dig_sel = 4'd0;
        seg = 7'd0;
        out_ready = 1'b1;
        reset = 1'b1;
        // Test 1: reset values and mid-frame reset discards partial slots
        do_reset;
        check("t1_in_ready", in_ready, 1);
        check("t1_out_valid", out_valid, 0);
        check("t1_out_value", out_value, 16'h0000);
        check("t1_overrun", overrun, 0);
        check("t1_frame_err", frame_err, 0);
        send(4'b1000, 7'h06);
        send(4'b0100, 7'h5B);
        do_reset;
        check("t1_mid_in_ready", in_ready, 1);
        check("t1_mid_out_valid", out_valid, 0);
        send(4'b0010, 7'h4F);
        send(4'b0001, 7'h66);
        check("t1_partial_discarded", in_ready, 1);
        send(4'b1000, 7'h06);
        send(4'b0100, 7'h5B);
        check("t1_frame_completes", in_ready, 0);
        // Test 2: three clean frames report 1234 with 2-cycle latency
        do_reset;
        b_ov = ov_rises;
        frame(7'h06, 7'h5B, 7'h4F, 7'h66);
        frame(7'h06, 7'h5B, 7'h4F, 7'h66);
        tick(3);
        check("t2_no_early_report", ov_rises - b_ov, 0);
        frame(7'h06, 7'h5B, 7'h4F, 7'h66);
        check("t2_lat_eval", out_valid, 0);
        tick(1);
        check("t2_lat_valid", out_valid, 1);
        check("t2_value", out_value, 16'h1234);
        tick(3);
        check("t2_one_report", ov_rises - b_ov, 1);
        check("t2_valid_drop", out_valid, 0);
        // Test 3: blank digit breaks the stability run
        do_reset;
        b_ov = ov_rises;
        b_fe = fe_cnt;
        frame(7'h06, 7'h5B, 7'h4F, 7'h66);
        frame(7'h06, 7'h00, 7'h4F, 7'h66);
        tick(3);
        check("t3_frame_err_once", fe_cnt - b_fe, 1);
        check("t3_no_report", ov_rises - b_ov, 0);
        frame(7'h06, 7'h5B, 7'h4F, 7'h66);
        frame(7'h06, 7'h5B, 7'h4F, 7'h66);
        tick(3);
        check("t3_not_yet", ov_rises - b_ov, 0);
        frame(7'h06, 7'h5B, 7'h4F, 7'h66);
        tick(1);
        check("t3_valid", out_valid, 1);
        check("t3_value", out_value, 16'h1234);
        tick(2);
        check("t3_one_report", ov_rises - b_ov, 1);
        // Test 4: overrun while out_valid held, then BEEF after release
        do_reset;
        out_ready = 1'b0;
        repeat (3) frame(7'h06, 7'h5B, 7'h4F, 7'h66);
        tick(1);
        check("t4_valid_1234", out_valid, 1);
        check("t4_value_1234", out_value, 16'h1234);
        check("t4_no_overrun_yet", overrun, 0);
        repeat (3) frame(7'h7C, 7'h79, 7'h79, 7'h71);
        tick(1);
        check("t4_overrun", overrun, 1);
        check("t4_value_held", out_value, 16'h1234);
        check("t4_valid_held", out_valid, 1);
        out_ready = 1'b1;
        tick(1);
        check("t4_valid_drop", out_valid, 0);
        frame(7'h7C, 7'h79, 7'h79, 7'h71);
        tick(1);
        check("t4_valid_beef", out_valid, 1);
        check("t4_value_beef", out_value, 16'hBEEF);
        tick(1);
        check("t4_overrun_sticky", overrun, 1);
        // Test 5: ten identical frames report once; non-one-hot select ignored
        b_ov = ov_rises;
        repeat (10) frame(7'h06, 7'h5B, 7'h4F, 7'h66);
        tick(3);
        check("t5_one_report", ov_rises - b_ov, 1);
        check("t5_value", out_value, 16'h1234);
        b_fe = fe_cnt;
        send(4'b0011, 7'h06);
        tick(2);
        check("t5_bad_sel_err", fe_cnt - b_fe, 1);
        send(4'b1000, 7'h06);
        send(4'b0100, 7'h5B);
        send(4'b0010, 7'h4F);
        check("t5_bad_sel_no_seen", in_ready, 1);
        send(4'b0001, 7'h66);
        check("t5_frame_completes", in_ready, 0);
        // Test 6: repeated digit within a frame, last sample wins
        do_reset;
        repeat (3) begin
            send(4'b0001, 7'h06);
            send(4'b0001, 7'h66);
            send(4'b1000, 7'h06);
            send(4'b0100, 7'h5B);
            send(4'b0010, 7'h4F);
        end
        tick(1);
        check("t6_valid", out_valid, 1);
        check("t6_low_nibble", out_value[3:0], 4'h4);
        check("t6_value", out_value, 16'h1234);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
